board_io_conditioner: RTL and testbench
=======================================

BOARD_IO_CONDITIONER -- requirements
Module: board_io_conditioner

Interface
REQ-001 Parameter NUM_IN, default 8: number of raw button/switch input channels.
REQ-002 Parameter DEB_LIMIT, default 50000: stable-cycle count required before a debounced output changes; legal range is >= 1.
REQ-003 Parameter NUM_LED, default 16: number of PWM-driven LED output channels.
REQ-004 Parameter PWM_W, default 8: width of the PWM counter and of the duty value.
REQ-005 One clock; reset is asynchronous and active-low. Ports are clk and rst_n.
REQ-006 clk  input  1: sole clock; all state updates on its rising edge.
REQ-007 rst_n  input  1: asynchronous active-low reset.
REQ-008 raw_i  input  NUM_IN: asynchronous board inputs (buttons, switches).
REQ-009 deb_o  output  NUM_IN: synchronised, debounced level per channel.
REQ-010 rise_o  output  NUM_IN: one-cycle pulse when deb_o goes 0->1.
REQ-011 fall_o  output  NUM_IN: one-cycle pulse when deb_o goes 1->0.
REQ-012 led_en_i  input  NUM_LED: per-LED enable (from gpio_out).
REQ-013 duty_i  input  PWM_W: global brightness request.
REQ-014 led_o  output  NUM_LED: registered PWM LED drive.

Function
REQ-015 Each raw_i bit SHALL pass through a 2-flop synchroniser before any other logic uses it.
REQ-016 Each channel SHALL have an independent debounce counter of width $clog2(DEB_LIMIT+1).
REQ-017 When the synchronised level equals deb_o, the channel counter SHALL be cleared to 0.
REQ-018 When the synchronised level differs from deb_o and the counter is below DEB_LIMIT-1, the counter SHALL increment by 1.
REQ-019 When the synchronised level differs and the counter equals DEB_LIMIT-1, the following SHALL happen on the next edge:
- deb_o takes the synchronised level;
- the counter clears to 0.
REQ-020 A raw change held stable SHALL appear on deb_o exactly DEB_LIMIT+2 rising edges after the first edge that samples it.
REQ-021 A glitch shorter than DEB_LIMIT synchronised cycles SHALL NOT change deb_o, and SHALL leave the counter at 0 once the input returns.
REQ-022 rise_o / fall_o SHALL be registered and asserted in exactly the cycle deb_o first shows its new value, for one cycle only.
REQ-023 rise_o and fall_o SHALL never both be high on the same channel.
REQ-024 With DEB_LIMIT=1, deb_o SHALL follow the synchronised level with one cycle of latency.
REQ-025 A PWM_W-bit free-running counter pwm_cnt SHALL increment every cycle and wrap from 2^PWM_W-1 to 0.
REQ-026 An internal duty register duty_q SHALL load duty_i only on the cycle pwm_cnt equals 2^PWM_W-1, so that duty changes take effect at period boundaries only (glitch-free).
REQ-027 led_o[i] SHALL be registered as led_en_i[i] AND on, where on = (pwm_cnt < duty_q) OR (duty_q == 2^PWM_W-1).
REQ-028 Brightness at the boundary values SHALL be:
- duty_q = 0: LEDs fully off;
- duty_q = all-ones: LEDs fully on (100%);
- otherwise: on for duty_q of every 2^PWM_W cycles.
REQ-029 Changing led_en_i SHALL affect led_o on the next edge, independent of the PWM period.

Reset
REQ-030 On rst_n low, the following SHALL clear to 0 immediately, regardless of clk:
- synchronisers, debounce counters, deb_o, rise_o, fall_o;
- pwm_cnt, duty_q, led_o.
REQ-031 Reset asserted mid-debounce SHALL discard partial counts; after release, a channel whose input is held 1 SHALL reach deb_o=1 after DEB_LIMIT+2 edges and produce one rise_o pulse.
REQ-032 After reset release, duty_i SHALL first take effect at the first pwm_cnt wrap (2^PWM_W cycles after release).

Verification (DEB_LIMIT=4, PWM_W=3, NUM_IN=2, NUM_LED=2)
REQ-033 raw_i[0] 0->1 held -> deb_o[0]=1 exactly 6 edges later; rise_o[0] high that cycle only; fall_o[0]=0 throughout.
REQ-034 raw_i[1] high for 3 cycles then low -> deb_o[1] stays 0; no rise_o/fall_o pulses.
REQ-035 duty_i=3, led_en_i=2'b11 -> after first wrap, led_o=2'b11 for 3 of every 8 cycles; duty_i=0 -> 0 of 8; duty_i=7 -> 8 of 8.
REQ-036 duty_i changed 3->6 mid-period -> current period keeps 3 on-cycles; the next period has 6.
REQ-037 rst_n pulsed low while a counter is at 2 and led_o=1 -> all outputs 0 asynchronously; after release, the debounce restarts with a full 6-edge latency.

Source files
------------

// File: rtl/board_io_conditioner.sv
// Board input conditioning (2-flop sync, per-channel debounce, edge pulses)
// and globally dimmed PWM LED drive with period-aligned duty updates.
module board_io_conditioner #(
   parameter int unsigned NUM_IN    = 8,
   parameter int unsigned DEB_LIMIT = 50000,
   parameter int unsigned NUM_LED   = 16,
   parameter int unsigned PWM_W     = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_IN-1:0]  raw_i,
   output logic [NUM_IN-1:0]  deb_o,
   output logic [NUM_IN-1:0]  rise_o,
   output logic [NUM_IN-1:0]  fall_o,
   input  logic [NUM_LED-1:0] led_en_i,
   input  logic [PWM_W-1:0]   duty_i,
   output logic [NUM_LED-1:0] led_o
);

   localparam int unsigned      CNT_W    = $clog2(DEB_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_LIMIT - 1);
   localparam logic [PWM_W-1:0] PWM_MAX  = '1;

   logic [NUM_IN-1:0] sync_a;
   logic [NUM_IN-1:0] sync_b;
   logic [CNT_W-1:0]  cnt_q [NUM_IN];
   logic [CNT_W-1:0]  cnt_d [NUM_IN];
   logic [NUM_IN-1:0] deb_d;
   logic [NUM_IN-1:0] rise_d;
   logic [NUM_IN-1:0] fall_d;

   logic [PWM_W-1:0]  pwm_cnt;
   logic [PWM_W-1:0]  duty_q;
   logic              pwm_on;

   // Debounce: the counter only runs while the synced level disagrees with deb_o
   always_comb begin
      deb_d  = deb_o;
      rise_d = '0;
      fall_d = '0;
      for (int i = 0; i < int'(NUM_IN); i++) begin
         cnt_d[i] = '0;
         if (sync_b[i] != deb_o[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               deb_d[i]  = sync_b[i];
               rise_d[i] = sync_b[i];
               fall_d[i] = ~sync_b[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_a <= '0;
         sync_b <= '0;
         deb_o  <= '0;
         rise_o <= '0;
         fall_o <= '0;
         for (int i = 0; i < int'(NUM_IN); i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync_a <= raw_i;
         sync_b <= sync_a;
         deb_o  <= deb_d;
         rise_o <= rise_d;
         fall_o <= fall_d;
         for (int i = 0; i < int'(NUM_IN); i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // All-ones duty means fully on rather than (2^PWM_W-1)/2^PWM_W
   always_comb begin
      pwm_on = (pwm_cnt < duty_q) || (duty_q == PWM_MAX);
   end

   // Duty is latched only on the last count so a period is never cut short
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt <= '0;
         duty_q  <= '0;
         led_o   <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + PWM_W'(1);
         if (pwm_cnt == PWM_MAX) begin
            duty_q <= duty_i;
         end
         led_o <= led_en_i & {NUM_LED{pwm_on}};
      end
   end

endmodule

// File: tb/tb_board_io_conditioner.sv
// Bench for board_io_conditioner: directed vector table, PWM period sequences,
// async reset mid-debounce and random stimulus against a window-based model.
module tb_board_io_conditioner;

   localparam int unsigned NI = 2;
   localparam int unsigned NL = 2;
   localparam int unsigned PW = 3;
   localparam int          L  = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [NI-1:0] raw = '0;
   logic [NL-1:0] en = '0;
   logic [PW-1:0] duty = '0;
   logic [NI-1:0] deb, rise, fall;
   logic [NL-1:0] led;
   logic [NI-1:0] deb1, rise1, fall1;
   logic [NL-1:0] led1;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   board_io_conditioner #(.NUM_IN(NI), .DEB_LIMIT(L), .NUM_LED(NL), .PWM_W(PW)) dut (
      .clk(clk), .rst_n(rst_n), .raw_i(raw), .deb_o(deb), .rise_o(rise), .fall_o(fall),
      .led_en_i(en), .duty_i(duty), .led_o(led));

   board_io_conditioner #(.NUM_IN(NI), .DEB_LIMIT(1), .NUM_LED(NL), .PWM_W(PW)) dut1 (
      .clk(clk), .rst_n(rst_n), .raw_i(raw), .deb_o(deb1), .rise_o(rise1), .fall_o(fall1),
      .led_en_i(en), .duty_i(duty), .led_o(led1));

   // Model state: hist[j] holds the raw value sampled j+1 edges ago
   logic [NI-1:0] hist [L+1];
   logic [NI-1:0] m_deb, m_rise, m_fall;
   logic [NI-1:0] m_deb1, m_rise1, m_fall1;
   logic [PW-1:0] m_dq;
   logic [NL-1:0] m_led;
   int            m_cyc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int j = 0; j <= L; j++) hist[j] = '0;
      m_deb = '0; m_rise = '0; m_fall = '0;
      m_deb1 = '0; m_rise1 = '0; m_fall1 = '0;
      m_dq = '0; m_led = '0; m_cyc = 0;
   endtask

   // A channel flips once its last L synchronised samples all disagree with it
   task automatic model_edge(input logic [NI-1:0] r, input logic [NL-1:0] e, input logic [PW-1:0] d);
      logic [NI-1:0] nd;
      logic [NI-1:0] nd1;
      int pos;
      logic on;
      for (int ch = 0; ch < int'(NI); ch++) begin
         logic all_diff;
         all_diff = 1'b1;
         for (int j = 1; j <= L; j++) if (hist[j][ch] == m_deb[ch]) all_diff = 1'b0;
         nd[ch] = all_diff ? ~m_deb[ch] : m_deb[ch];
      end
      nd1 = hist[1];
      m_rise = nd & ~m_deb;  m_fall = ~nd & m_deb;  m_deb = nd;
      m_rise1 = nd1 & ~m_deb1; m_fall1 = ~nd1 & m_deb1; m_deb1 = nd1;
      for (int j = L; j >= 1; j--) hist[j] = hist[j-1];
      hist[0] = r;
      pos = m_cyc % (1 << PW);
      on = (pos < int'(m_dq)) || (int'(m_dq) == (1 << PW) - 1);
      m_led = on ? e : '0;
      if (pos == (1 << PW) - 1) m_dq = d;
      m_cyc++;
   endtask

   task automatic tick(input logic [NI-1:0] r, input logic [NL-1:0] e, input logic [PW-1:0] d);
      raw = r; en = e; duty = d;
      @(posedge clk);
      model_edge(r, e, d);
      #1;
      chk("deb", 32'(deb), 32'(m_deb));
      chk("rise", 32'(rise), 32'(m_rise));
      chk("fall", 32'(fall), 32'(m_fall));
      chk("led", 32'(led), 32'(m_led));
      chk("rise_and_fall", 32'(rise & fall), 32'd0);
      chk("deb_lim1", 32'(deb1), 32'(m_deb1));
      chk("rise_lim1", 32'(rise1), 32'(m_rise1));
      chk("fall_lim1", 32'(fall1), 32'(m_fall1));
      chk("led_lim1", 32'(led1), 32'(m_led));
   endtask

   task automatic do_reset();
      @(negedge clk);
      raw = '0; en = '0; duty = '0;
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      chk("reset_deb", 32'(deb), 32'd0);
      chk("reset_led", 32'(led), 32'd0);
      rst_n = 1'b1;
   endtask

   task automatic run_period(input logic [PW-1:0] d1, input logic [PW-1:0] d2, output int ones);
      ones = 0;
      for (int i = 0; i < (1 << PW); i++) begin
         tick('0, 2'b11, (i < 4) ? d1 : d2);
         if (led == 2'b11) ones++;
      end
   endtask

   typedef struct {
      logic [NI-1:0] raw;
      logic [NI-1:0] deb;
      logic [NI-1:0] rise;
      logic [NI-1:0] fall;
   } vec_t;

   vec_t tbl [16];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ones;
      int first_hi;
      int rises;
      logic [NI-1:0] r;
      logic [NL-1:0] e;
      logic [PW-1:0] d;

      // ch1 glitches high for 3 samples; ch0 rises then falls after being held
      tbl[0]  = '{2'b11, 2'b00, 2'b00, 2'b00};
      tbl[1]  = '{2'b11, 2'b00, 2'b00, 2'b00};
      tbl[2]  = '{2'b11, 2'b00, 2'b00, 2'b00};
      tbl[3]  = '{2'b01, 2'b00, 2'b00, 2'b00};
      tbl[4]  = '{2'b01, 2'b00, 2'b00, 2'b00};
      tbl[5]  = '{2'b01, 2'b01, 2'b01, 2'b00};
      tbl[6]  = '{2'b01, 2'b01, 2'b00, 2'b00};
      tbl[7]  = '{2'b01, 2'b01, 2'b00, 2'b00};
      tbl[8]  = '{2'b01, 2'b01, 2'b00, 2'b00};
      tbl[9]  = '{2'b01, 2'b01, 2'b00, 2'b00};
      tbl[10] = '{2'b00, 2'b01, 2'b00, 2'b00};
      tbl[11] = '{2'b00, 2'b01, 2'b00, 2'b00};
      tbl[12] = '{2'b00, 2'b01, 2'b00, 2'b00};
      tbl[13] = '{2'b00, 2'b01, 2'b00, 2'b00};
      tbl[14] = '{2'b00, 2'b01, 2'b00, 2'b00};
      tbl[15] = '{2'b00, 2'b00, 2'b00, 2'b01};

      model_reset();
      #2;
      chk("por_deb", 32'(deb), 32'd0);
      chk("por_led", 32'(led), 32'd0);
      do_reset();

      for (int k = 0; k < 16; k++) begin
         tick(tbl[k].raw, '0, '0);
         chk($sformatf("tbl%0d_deb", k), 32'(deb), 32'(tbl[k].deb));
         chk($sformatf("tbl%0d_rise", k), 32'(rise), 32'(tbl[k].rise));
         chk($sformatf("tbl%0d_fall", k), 32'(fall), 32'(tbl[k].fall));
      end

      // PWM: duty only takes effect from the period after it is latched
      do_reset();
      run_period(3'd3, 3'd3, ones); chk("pwm_first_period_dark", 32'(ones), 32'd0);
      run_period(3'd0, 3'd0, ones); chk("pwm_duty3", 32'(ones), 32'd3);
      run_period(3'd7, 3'd7, ones); chk("pwm_duty0", 32'(ones), 32'd0);
      run_period(3'd3, 3'd3, ones); chk("pwm_duty7", 32'(ones), 32'd8);
      run_period(3'd3, 3'd6, ones); chk("pwm_mid_change_keeps3", 32'(ones), 32'd3);
      run_period(3'd6, 3'd6, ones); chk("pwm_next_period6", 32'(ones), 32'd6);
      tick('0, 2'b01, 3'd6);
      tick('0, 2'b10, 3'd6);

      // Async reset while ch0 counter is part-way and LEDs are lit
      do_reset();
      for (int i = 0; i < (1 << PW); i++) tick('0, 2'b11, 3'd7);
      for (int i = 0; i < 4; i++) tick(2'b01, 2'b11, 3'd7);
      chk("pre_reset_led", 32'(led), 32'h3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_deb", 32'(deb), 32'd0);
      chk("async_rst_rise", 32'(rise), 32'd0);
      chk("async_rst_fall", 32'(fall), 32'd0);
      chk("async_rst_led", 32'(led), 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      first_hi = 0;
      rises = 0;
      for (int i = 1; i <= 10; i++) begin
         tick(2'b01, 2'b11, 3'd7);
         if (deb[0] && first_hi == 0) first_hi = i;
         if (rise[0]) rises++;
      end
      chk("post_reset_latency", 32'(first_hi), 32'd6);
      chk("post_reset_rise_count", 32'(rises), 32'd1);

      // Random: slow-changing inputs so both glitches and real edges occur
      do_reset();
      r = '0; e = 2'b11; d = 3'd4;
      for (int i = 0; i < 3000; i++) begin
         for (int b = 0; b < int'(NI); b++) if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
         if ($urandom_range(0, 7) == 0) e = NL'($urandom);
         if ($urandom_range(0, 15) == 0) d = PW'($urandom);
         tick(r, e, d);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
